// File: rtl/wb_port_sched_if.sv
// Handshake bundle between the writeback mux, the load-return path and the
// register-file write port.
interface wb_port_sched_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              pipe_valid;
    logic [REG_W-1:0]  pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;
    logic              mem_valid;
    logic [REG_W-1:0]  mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output pipe_valid, pipe_reg, pipe_data,
        output mem_valid, mem_reg, mem_data,
        input  pipe_stall, mem_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_valid, pipe_reg, pipe_data,
        input  mem_valid, mem_reg, mem_data,
        output pipe_stall, mem_ready,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: pipe writes vs. queued load returns.
// Optional WB_SCHED_BYPASS_EN sends a load straight to the port when idle.
module wb_port_sched #(
    parameter int DATA_W       = 16,
    parameter int REG_W        = 3,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wb_port_sched_if.slave           bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = REG_W + DATA_W;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_MEM
    } src_e;

    logic [EW-1:0]     fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              err_q, err_d;
    logic              mem_ready_q, mem_ready_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    src_e              src;
    logic              empty, full, force_pop;
    logic              push, pop, stall;
    logic [EW-1:0]     head;

    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        force_pop = !empty && (full || starve_q == SW'(STARVE_LIMIT));
        src       = SRC_NONE;
        stall     = 1'b0;
        if (force_pop) begin
            src   = SRC_FIFO;
            stall = bus.pipe_valid;
        end else if (bus.pipe_valid) begin
            src = SRC_PIPE;
        end
`ifdef WB_SCHED_BYPASS_EN
        else if (empty && bus.mem_valid) begin
            src = SRC_MEM;
        end
`endif
        else if (!empty) begin
            src = SRC_FIFO;
        end
    end

    always_comb begin
        pop  = (src == SRC_FIFO);
        push = bus.mem_valid && !full && (src != SRC_MEM);

        rf_we_d    = (src != SRC_NONE);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (src)
            SRC_PIPE: begin
                rf_waddr_d = bus.pipe_reg;
                rf_wdata_d = bus.pipe_data;
            end
            SRC_FIFO: {rf_waddr_d, rf_wdata_d} = head;
            SRC_MEM: begin
                rf_waddr_d = bus.mem_reg;
                rf_wdata_d = bus.mem_data;
            end
            default: ;
        endcase

        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        mem_ready_d = (count_d < CW'(DEPTH));
        // A full FIFO cannot accept the beat even if the head pops this cycle.
        err_d       = err_q | (bus.mem_valid && full);

        starve_d = starve_q;
        if (pop || empty)
            starve_d = '0;
        else if (src == SRC_PIPE && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            mem_ready_q <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            err_q       <= err_d;
            mem_ready_q <= mem_ready_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= {bus.mem_reg, bus.mem_data};
    end

    assign bus.pipe_stall = stall;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign fifo_count     = count_q;
    assign err            = err_q;
endmodule
